// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 refresh sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, LINE, FETCH, CHAR, CURSOR, GAP, IDLE
  } lcd_state_t;

  typedef enum logic [1:0] {
    WS_IDLE, WS_SETUP, WS_PULSE, WS_WAIT
  } ws_phase_t;

  localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_DISP_BLINK = 8'h0F;
  localparam logic [7:0] LCD_ENTRY      = 8'h06;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_LINE1      = 8'h80;
  localparam logic [7:0] LCD_LINE2      = 8'hC0;
  localparam int         LCD_CHARS      = 32;

  // Init command for a given step of the power-up sequence.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: 1 setup cycle, EN_PULSE_CYC cycles of lcd_e high, then the selected wait.
// Latency: start -> done = 1 + EN_PULSE_CYC + wait cycles (done is high in the final cycle).
// Backpressure: start is accepted only while idle; rs/data stay latched until the next start.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int CW           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       clr_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [CW-1:0] EP_LAST = CW'(EN_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LEN = CW'(CMD_WAIT_CYC);
  localparam logic [CW-1:0] CLR_LEN = CW'(CLR_WAIT_CYC);

  ws_phase_t     phase, phase_nxt;
  logic [CW-1:0] cnt, cnt_nxt, wait_len, wait_nxt;
  logic          rs_nxt;
  logic [7:0]    data_nxt;

  // lcd_e comes straight from the phase register so reset drops it immediately.
  assign lcd_e = (phase == WS_PULSE);

  // Phase register and latched bus values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= WS_IDLE;
      cnt      <= '0;
      wait_len <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      wait_len <= wait_nxt;
      lcd_rs   <= rs_nxt;
      lcd_data <= data_nxt;
    end
  end

  // Setup -> pulse -> wait sequencing; zero-length pulse or wait phases are skipped.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    wait_nxt  = wait_len;
    rs_nxt    = lcd_rs;
    data_nxt  = lcd_data;
    done      = 1'b0;
    case (phase)
      WS_IDLE: if (start) begin
        phase_nxt = WS_SETUP;
        cnt_nxt   = '0;
        rs_nxt    = rs;
        data_nxt  = data;
        wait_nxt  = clr_wait ? CLR_LEN : CMD_LEN;
      end
      WS_SETUP: begin
        if (EN_PULSE_CYC != 0) phase_nxt = WS_PULSE;
        else if (wait_len != '0) phase_nxt = WS_WAIT;
        else begin
          phase_nxt = WS_IDLE;
          done      = 1'b1;
        end
      end
      WS_PULSE: begin
        if (cnt == EP_LAST) begin
          cnt_nxt = '0;
          if (wait_len == '0) begin
            phase_nxt = WS_IDLE;
            done      = 1'b1;
          end else begin
            phase_nxt = WS_WAIT;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WS_WAIT: begin
        if (cnt == wait_len - CW'(1)) begin
          phase_nxt = WS_IDLE;
          cnt_nxt   = '0;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: phase_nxt = WS_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 LCD sequencer: power-up init, then endless 32-char sweeps from the content block.
// Latency: first command after PWR_WAIT_CYC; one char per FETCH (2 cycles) plus one write.
// Backpressure: refresh_en only gates frame starts; LCD_CURSOR_BLINK_EN adds cursor commands per frame.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int PWR_WAIT_CYC = 750000,
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int GAP_CYC      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh_en,
  input  logic [7:0] char_in,
`ifdef LCD_CURSOR_BLINK_EN
  input  logic [4:0] cursor_pos,
  input  logic       cursor_on,
`endif
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAXP = max_int(max_int(max_int(PWR_WAIT_CYC, EN_PULSE_CYC),
                                        max_int(CMD_WAIT_CYC, CLR_WAIT_CYC)), max_int(GAP_CYC, 2));
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT_CYC - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC);

  lcd_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    step, step_nxt;
  logic          issued, issued_nxt, adv;
  logic [4:0]    index_nxt;
  logic [7:0]    char_q, char_nxt;
  logic          init_nxt, fd_nxt;
  logic          wr_start, wr_rs, wr_done;
  logic [7:0]    wr_data;

  assign lcd_rw = 1'b0;
  assign adv    = issued && wr_done;

  lcd_write_strobe #(
    .EN_PULSE_CYC (EN_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC),
    .CW           (CW)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .clr_wait (!wr_rs && (wr_data == LCD_CLEAR)),
    .done     (wr_done),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  // Sequencer state, counters and captured char.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      step       <= 2'd0;
      issued     <= 1'b0;
      index      <= 5'd0;
      char_q     <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      step       <= step_nxt;
      issued     <= issued_nxt;
      index      <= index_nxt;
      char_q     <= char_nxt;
      init_done  <= init_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Next-state logic; each write state issues one strobe and advances on its done.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    step_nxt   = step;
    issued_nxt = issued;
    index_nxt  = index;
    char_nxt   = char_q;
    init_nxt   = init_done;
    fd_nxt     = 1'b0;
    wr_start   = 1'b0;
    wr_rs      = 1'b0;
    wr_data    = LCD_DISP_ON;
    if (state inside {INIT, LINE, CHAR, CURSOR}) begin
      if (!issued) begin
        wr_start   = 1'b1;
        issued_nxt = 1'b1;
      end else if (wr_done) begin
        issued_nxt = 1'b0;
      end
    end
    case (state)
      PWR_WAIT: begin
        if (PWR_WAIT_CYC == 0 || cnt == PWR_LAST) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      INIT: begin
        wr_data = init_cmd(step);
        if (adv) begin
          if (step == 2'd3) begin
            step_nxt  = 2'd0;
            init_nxt  = 1'b1;
            state_nxt = LINE;
          end else begin
            step_nxt = step + 2'd1;
          end
        end
      end
      LINE: begin
        wr_data = (index == 5'd0) ? LCD_LINE1 : LCD_LINE2;
        if (adv) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        // Content block answers one cycle after index moves; take it on the second cycle.
        if (cnt == CW'(1)) begin
          char_nxt  = char_in;
          state_nxt = CHAR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      CHAR: begin
        wr_rs   = 1'b1;
        wr_data = char_q;
        if (adv) begin
          cnt_nxt = '0;
          if (index == 5'd15) begin
            index_nxt = 5'd16;
            state_nxt = LINE;
          end else if (index == 5'(LCD_CHARS - 1)) begin
            index_nxt = 5'd0;
            fd_nxt    = 1'b1;
`ifdef LCD_CURSOR_BLINK_EN
            state_nxt = CURSOR;
`else
            state_nxt = GAP;
`endif
          end else begin
            index_nxt = index + 5'd1;
            state_nxt = FETCH;
          end
        end
      end
`ifdef LCD_CURSOR_BLINK_EN
      CURSOR: begin
        if (step == 2'd0) wr_data = (cursor_pos[4] ? LCD_LINE2 : LCD_LINE1) | {4'h0, cursor_pos[3:0]};
        else              wr_data = cursor_on ? LCD_DISP_BLINK : LCD_DISP_ON;
        if (adv) begin
          if (step == 2'd0) begin
            step_nxt = 2'd1;
          end else begin
            step_nxt  = 2'd0;
            state_nxt = GAP;
            cnt_nxt   = '0;
          end
        end
      end
`endif
      GAP: begin
        if (cnt == GAP_END) begin
          state_nxt = refresh_en ? LINE : IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      IDLE: if (refresh_en) state_nxt = LINE;
      default: state_nxt = PWR_WAIT;
    endcase
  end

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Self-checking bench: random content, write-level reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_refresh_ctrl;

  localparam int PWR = 20;
  localparam int EP  = 4;
  localparam int CMD = 10;
  localparam int CLR = 50;
`ifdef LCD_CURSOR_BLINK_EN
  localparam int FRAME_LEN = 36;
`else
  localparam int FRAME_LEN = 34;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       refresh_en;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0] lcd_data;
`ifdef LCD_CURSOR_BLINK_EN
  logic [4:0] cursor_pos;
  logic       cursor_on;
`endif

  always #5 clk = ~clk;

  lcd_refresh_ctrl #(
    .PWR_WAIT_CYC (PWR),
    .EN_PULSE_CYC (EP),
    .CMD_WAIT_CYC (CMD),
    .CLR_WAIT_CYC (CLR),
    .GAP_CYC      (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh_en (refresh_en),
    .char_in    (char_in),
`ifdef LCD_CURSOR_BLINK_EN
    .cursor_pos (cursor_pos),
    .cursor_on  (cursor_on),
`endif
    .index      (index),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  // Content block: registered lookup, corrupted by noise whenever lcd_e is high.
  logic [7:0] tbl [32];
  logic [7:0] content_q, noise;
  always @(posedge clk) begin
    content_q <= tbl[index];
    noise     <= 8'($urandom_range(1, 255));
  end
  assign char_in = lcd_e ? (content_q ^ noise) : content_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: position in the init list and in the frame.
  int         mi, fpos, hc, lc, cur_wait, fd_seen, last_char, nwr;
  bit         have_wr, cur_final, cur_init_last, exp_init;
  logic       cur_rs, prev_e, prev_rs;
  logic [7:0] cur_data, prev_data;
  logic [7:0] wlog [64];

  task automatic expect_next(output logic e_rs, output logic [7:0] e_data, output int e_idx,
                             output int e_char);
    e_rs = 1'b0; e_data = 8'h00; e_idx = 0; e_char = -1;
    if (mi < 4) begin
      case (mi)
        0: e_data = 8'h38;
        1: e_data = 8'h0C;
        2: e_data = 8'h06;
        default: e_data = 8'h01;
      endcase
    end else if (fpos == 0) begin
      e_data = 8'h80;
    end else if (fpos <= 16) begin
      e_rs = 1'b1; e_char = fpos - 1; e_idx = e_char; e_data = tbl[e_char];
    end else if (fpos == 17) begin
      e_data = 8'hC0; e_idx = 16;
    end else if (fpos <= 33) begin
      e_rs = 1'b1; e_char = fpos - 2; e_idx = e_char; e_data = tbl[e_char];
`ifdef LCD_CURSOR_BLINK_EN
    end else if (fpos == 34) begin
      e_data = (cursor_pos[4] ? 8'hC0 : 8'h80) + {4'h0, cursor_pos[3:0]};
    end else begin
      e_data = cursor_on ? 8'h0F : 8'h0C;
`endif
    end
  endtask

  // Compare process: checks every write and every cycle's flags against the model.
  always @(negedge clk) begin
    logic       e_rs;
    logic [7:0] e_data;
    int         e_idx, e_char;
    bit         exp_fd;
    if (rst) begin
      mi = 0; fpos = 0; have_wr = 0; exp_init = 0; hc = 0; lc = 0; last_char = -1;
      check("rst_e", lcd_e, 0);
      check("rst_index", index, 0);
      check("rst_rs_data", {lcd_rs, lcd_data}, 0);
      check("rst_init_done", init_done, 0);
      check("rst_frame_done", frame_done, 0);
    end else begin
      check("rw", lcd_rw, 0);
      if (lcd_e && !prev_e) begin
        expect_next(e_rs, e_data, e_idx, e_char);
        check("wr_rs", lcd_rs, e_rs);
        check("wr_data", lcd_data, e_data);
        check("wr_index", index, e_idx);
        check("setup", {prev_rs, prev_data}, {lcd_rs, lcd_data});
        if (!have_wr) check("pwr_wait_len", (lc >= PWR) && (lc <= PWR + 4), 1);
        else          check("min_gap", lc >= cur_wait + 1, 1);
        if (have_wr && mi >= 1 && mi <= 3) check("init_gap", lc <= cur_wait + 3, 1);
        if (nwr < 64) wlog[nwr] = lcd_data;
        nwr++;
        cur_rs = e_rs; cur_data = e_data;
        cur_wait = (!e_rs && e_data == 8'h01) ? CLR : CMD;
        cur_final = (e_char == 31);
        cur_init_last = (mi == 3);
        last_char = e_char;
        have_wr = 1; hc = 1;
        if (mi < 4) mi++;
        else fpos = (fpos + 1) % FRAME_LEN;
      end else if (lcd_e) begin
        hc++;
        check("pulse_hold", {lcd_rs, lcd_data}, {cur_rs, cur_data});
      end else begin
        if (prev_e) begin
          check("pulse_len", hc, EP);
          lc = 0;
        end
        if (have_wr && lc < cur_wait) check("wait_hold", {lcd_rs, lcd_data}, {cur_rs, cur_data});
      end
      exp_fd = have_wr && cur_final && !lcd_e && (lc == cur_wait);
      if (have_wr && cur_init_last && !lcd_e && lc == cur_wait) exp_init = 1;
      check("frame_done", frame_done, exp_fd);
      check("init_done", init_done, exp_init);
      if (frame_done) fd_seen++;
      if (!lcd_e) lc++;
    end
    prev_e = lcd_e; prev_rs = lcd_rs; prev_data = lcd_data;
  end

  task automatic wait_fd(input int target, input string name);
    for (int n = 0; n < 4000 && fd_seen < target; n++) @(posedge clk);
    check(name, fd_seen >= target, 1);
  endtask

  task automatic wait_char(input int c, input string name);
    for (int n = 0; n < 4000 && !(last_char == c && lcd_e); n++) @(posedge clk);
    check(name, last_char == c && lcd_e, 1);
  endtask

  task automatic idle_quiet(input string name);
    int busy = 0;
    repeat (150) begin
      @(negedge clk);
      if (lcd_e) busy++;
    end
    check(name, busy, 0);
    check({name, "_index"}, index, 0);
  endtask

  initial begin
    rst = 1'b1; refresh_en = 1'b0; fd_seen = 0; nwr = 0;
    prev_e = 1'b0; prev_rs = 1'b0; prev_data = 8'h00;
    for (int i = 0; i < 32; i++) tbl[i] = 8'(8'h41 + i);
`ifdef LCD_CURSOR_BLINK_EN
    cursor_pos = 5'd21; cursor_on = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Init plus the first frame run even with refresh_en low, then the FSM idles.
    wait_fd(1, "first_frame_timeout");
    idle_quiet("idle_after_first");
    check("log_func_set", wlog[0], 8'h38);
    check("log_disp_on", wlog[1], 8'h0C);
    check("log_entry", wlog[2], 8'h06);
    check("log_clear", wlog[3], 8'h01);
    check("log_line1", wlog[4], 8'h80);
    check("log_char_A", wlog[5], 8'h41);
    check("log_char_P", wlog[20], 8'h50);
    check("log_line2", wlog[21], 8'hC0);
    check("log_char_Q", wlog[22], 8'h51);
    check("log_char_last", wlog[37], 8'h60);
`ifdef LCD_CURSOR_BLINK_EN
    check("log_cursor_pos", wlog[38], 8'hC5);
    check("log_cursor_on", wlog[39], 8'h0F);
`endif
    check("frame_write_count", nwr, 4 + FRAME_LEN);

    // Random content, continuous refresh, then stop requested mid-frame.
    for (int i = 0; i < 32; i++) tbl[i] = 8'($urandom);
    refresh_en = 1'b1;
    wait_fd(3, "refresh_timeout");
    wait_char(5, "char5_timeout");
    refresh_en = 1'b0;
    wait_fd(4, "drop_frame_timeout");
    idle_quiet("idle_after_drop");

    // Restart, then reset in the middle of char 20's enable pulse.
    for (int i = 0; i < 32; i++) tbl[i] = 8'($urandom);
`ifdef LCD_CURSOR_BLINK_EN
    cursor_on = 1'b0;
`endif
    @(posedge clk);
    #1 refresh_en = 1'b1;
    wait_char(20, "char20_timeout");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midwrite_rst_e", lcd_e, 0);
    check("midwrite_rst_init_done", init_done, 0);
    check("midwrite_rst_index", index, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 1000 && !init_done; n++) @(posedge clk);
    check("reinit_timeout", init_done, 1);
    wait_fd(fd_seen + 1, "post_reset_frame_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
